// File: rtl/div_seq_unit.sv
// Sequential radix-2 restoring divider for DIV/DIVU/REM/REMU.
// It latches the operand magnitudes and sign flags when a request is accepted.
// Divide-by-zero and signed overflow finish immediately.
// All other operations take one quotient bit per cycle for XLEN cycles.
// The sign fix-up is applied on the cycle that enters DONE.
//
// state  | meaning
// S_IDLE | waiting for start_i; a request is accepted here only
// S_CALC | one shift/subtract step per cycle, counter runs XLEN-1 down to 0
// S_DONE | one cycle: valid_o high, stall released so the instruction retires
module div_seq_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic [4:0]      rd_addr_i,
    output logic            busy_o,
    output logic            stall_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_dvs;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_op_rem;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_rd_out;

    logic              w_signed;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_div_zero;
    logic              w_ovf;
    logic              w_accept;
    logic [XLEN-1:0]   w_special;
    logic [XLEN:0]     w_sh_r;
    logic [XLEN:0]     w_diff;
    logic              w_ge;
    logic [XLEN-1:0]   w_rem_nxt;
    logic [XLEN-1:0]   w_quo_nxt;
    logic [XLEN-1:0]   w_q_fix;
    logic [XLEN-1:0]   w_r_fix;

    // Operand decode at accept: signs only count for signed ops, magnitudes in two's complement
    always_comb begin
        w_signed   = ~op_i[0];
        w_sa       = w_signed & dividend_i[XLEN-1];
        w_sb       = w_signed & divisor_i[XLEN-1];
        w_abs_a    = w_sa ? (~dividend_i + 1'b1) : dividend_i;
        w_abs_b    = w_sb ? (~divisor_i + 1'b1) : divisor_i;
        w_div_zero = (divisor_i == '0);
        w_ovf      = w_signed & (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) & (divisor_i == '1);
        w_accept   = (r_state == S_IDLE) & start_i & ~kill_i;
        // Overflow case: dividend is 0x80000000, which is also the required quotient
        if (w_div_zero) begin
            w_special = op_i[1] ? dividend_i : '1;
        end else begin
            w_special = op_i[1] ? '0 : dividend_i;
        end
    end

    // One restoring step: the XLEN+1 bit trial remainder; no borrow means R >= divisor
    always_comb begin
        w_sh_r    = {r_rem, r_quo[XLEN-1]};
        w_diff    = w_sh_r - {1'b0, r_dvs};
        w_ge      = ~w_diff[XLEN];
        w_rem_nxt = w_ge ? w_diff[XLEN-1:0] : w_sh_r[XLEN-1:0];
        w_quo_nxt = {r_quo[XLEN-2:0], w_ge};
        w_q_fix   = r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
        w_r_fix   = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
    end

    // Sequencer, datapath registers and registered result
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_op_rem <= 1'b0;
            r_rd     <= '0;
            r_result <= '0;
            r_rd_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rd     <= rd_addr_i;
                        r_op_rem <= op_i[1];
                        r_neg_q  <= w_sa ^ w_sb;
                        r_neg_r  <= w_sa;
                        r_quo    <= w_abs_a;
                        r_rem    <= '0;
                        r_dvs    <= w_abs_b;
                        if (w_div_zero || w_ovf) begin
                            r_result <= w_special;
                            r_rd_out <= rd_addr_i;
                            r_state  <= S_DONE;
                        end else begin
                            r_cnt   <= CNT_W'(XLEN - 1);
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (kill_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        if (r_cnt == '0) begin
                            r_result <= r_op_rem ? w_r_fix : w_q_fix;
                            r_rd_out <= r_rd;
                            r_state  <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs: a kill in DONE must drop the strobe in that same cycle
    always_comb begin
        busy_o    = (r_state != S_IDLE);
        stall_o   = w_accept | (r_state == S_CALC);
        valid_o   = (r_state == S_DONE) & ~kill_i;
        result_o  = r_result;
        rd_addr_o = r_rd_out;
    end

endmodule

// File: tb/tb_div_seq_unit.sv
// Directed and random checks of div_seq_unit against an arithmetic reference model.
module tb_div_seq_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        kill_i;
    logic [1:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [4:0]  rd_addr_i;
    logic        busy_o;
    logic        stall_o;
    logic        valid_o;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] last_result;
    logic [4:0]  last_rd;

    div_seq_unit #(.XLEN(32), .CNT_W(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .kill_i(kill_i),
        .op_i(op_i), .dividend_i(dividend_i), .divisor_i(divisor_i),
        .rd_addr_i(rd_addr_i), .busy_o(busy_o), .stall_o(stall_o),
        .valid_o(valid_o), .result_o(result_o), .rd_addr_o(rd_addr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // RISC-V divide semantics computed with 64-bit integer arithmetic
    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op at cycle T and check every cycle up to and just after valid_o
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit noise);
        logic [31:0] exp;
        int          lat;
        exp = ref_model(op, a, b);
        lat = ref_lat(op, a, b);
        op_i = op; dividend_i = a; divisor_i = b; rd_addr_i = rd;
        start_i = 1'b1; kill_i = 1'b0;
        #1;
        chk("accept_busy", busy_o, 0);
        chk("accept_stall", stall_o, 1);
        step();
        for (int c = 1; c < lat; c++) begin
            start_i = 1'b0;
            if (noise) begin
                start_i    = 1'($urandom_range(0, 1));
                op_i       = 2'($urandom_range(0, 3));
                dividend_i = $urandom;
                divisor_i  = $urandom;
                rd_addr_i  = 5'($urandom_range(0, 31));
            end
            #1;
            chk("calc_valid", valid_o, 0);
            chk("calc_stall", stall_o, 1);
            step();
        end
        start_i = 1'b0;
        #1;
        chk("done_valid", valid_o, 1);
        chk("done_stall", stall_o, 0);
        chk("done_result", result_o, exp);
        chk("done_rd", rd_addr_o, rd);
        last_result = exp;
        last_rd     = rd;
        step();
        chk("after_busy", busy_o, 0);
        chk("after_valid", valid_o, 0);
        chk("after_hold", result_o, exp);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [1:0]  op;
        int          pick;
        rst_i = 1'b1; start_i = 1'b0; kill_i = 1'b0; op_i = 2'd0;
        dividend_i = 32'd0; divisor_i = 32'd0; rd_addr_i = 5'd0;
        step();
        step();
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_rd", rd_addr_o, 0);
        chk("rst_stall", stall_o, 0);
        rst_i = 1'b0;
        step();

        // Test-plan directed ops: DIV, REM, DIVU, REMU and the special cases
        do_op(2'b00, 32'd100, 32'd7, 5'd11, 1'b0);
        do_op(2'b10, 32'd100, 32'd7, 5'd12, 1'b0);
        do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b0);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b0);
        do_op(2'b11, 32'hFFFF_FFFF, 32'h10, 5'd6, 1'b0);
        do_op(2'b00, 32'd123, 32'd0, 5'd7, 1'b0);
        do_op(2'b10, 32'd123, 32'd0, 5'd8, 1'b0);
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b0);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b0);
        do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b0);

        // Start toggling and operand changes during CALC are ignored
        do_op(2'b00, 32'hFFFF_FC18, 32'd37, 5'd14, 1'b1);

        // Kill in CALC at T+10: no strobe, result held, then a fresh op at T+12
        op_i = 2'b00; dividend_i = 32'd5000; divisor_i = 32'd9; rd_addr_i = 5'd20;
        start_i = 1'b1;
        #1;
        chk("kill_accept_stall", stall_o, 1);
        step();
        start_i = 1'b0;
        for (int c = 1; c < 10; c++) step();
        kill_i = 1'b1;
        #1;
        chk("kill_cycle_valid", valid_o, 0);
        step();
        kill_i = 1'b0;
        #1;
        chk("kill_busy", busy_o, 0);
        chk("kill_valid", valid_o, 0);
        chk("kill_result_held", result_o, last_result);
        chk("kill_rd_held", rd_addr_o, last_rd);
        step();
        do_op(2'b00, 32'd5000, 32'd9, 5'd21, 1'b0);

        // Kill together with start in IDLE: not accepted
        start_i = 1'b1; kill_i = 1'b1; divisor_i = 32'd3;
        #1;
        chk("killstart_stall", stall_o, 0);
        step();
        start_i = 1'b0; kill_i = 1'b0;
        #1;
        chk("killstart_busy", busy_o, 0);

        // Start held through DONE is accepted on the following IDLE cycle
        op_i = 2'b00; dividend_i = 32'd77; divisor_i = 32'd0; rd_addr_i = 5'd25;
        start_i = 1'b1;
        #1;
        chk("hold_stall0", stall_o, 1);
        step();
        chk("hold_done1_valid", valid_o, 1);
        chk("hold_done1_stall", stall_o, 0);
        chk("hold_done1_result", result_o, 32'hFFFF_FFFF);
        step();
        chk("hold_idle_busy", busy_o, 0);
        chk("hold_idle_stall", stall_o, 1);
        step();
        chk("hold_done2_valid", valid_o, 1);
        start_i = 1'b0;
        kill_i  = 1'b1;
        #1;
        chk("done_kill_valid", valid_o, 0);
        step();
        kill_i = 1'b0;
        last_result = 32'hFFFF_FFFF;
        last_rd     = 5'd25;

        // Reset at T+5 mid-CALC: outputs return to reset values, no strobe
        op_i = 2'b01; dividend_i = 32'd999; divisor_i = 32'd10; rd_addr_i = 5'd30;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int c = 1; c < 5; c++) step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1;
        chk("midrst_busy", busy_o, 0);
        chk("midrst_valid", valid_o, 0);
        chk("midrst_result", result_o, 0);
        chk("midrst_rd", rd_addr_o, 0);
        chk("midrst_stall", stall_o, 0);
        step();

        // Back-to-back random ops with boundary values mixed in
        for (int n = 0; n < 40; n++) begin
            pick = int'($urandom_range(0, 7));
            a    = $urandom;
            b    = $urandom;
            op   = 2'($urandom_range(0, 3));
            if (pick == 0) b = 32'd0;
            if (pick == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (pick == 2) b = 32'($urandom_range(1, 15));
            if (pick == 3) b = b >> $urandom_range(0, 31);
            if (pick == 4) b = 32'hFFFF_FFFF;
            do_op(op, a, b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
